// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch sequencer: owns the fetch PC, keeps requests in flight,
// tags responses with their PC and drops stale ones after a redirect.
module ifu_fetch_ctrl #(
  parameter int              PC_W      = 32,
  parameter int              INSTR_W   = 32,
  parameter logic [PC_W-1:0] RST_PC    = PC_W'(32'h8000_0000),
  parameter int              MAX_OUTST = 4,
  parameter int              CNT_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect_vld,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               req_vld,
  input  logic               req_rdy,
  output logic [PC_W-1:0]    req_pc,
  input  logic               rsp_vld_i,
  output logic               rsp_rdy_i,
  input  logic [INSTR_W-1:0] rsp_instr_i,
  output logic               rsp_vld_o,
  input  logic               rsp_rdy_o,
  output logic [PC_W-1:0]    rsp_pc_o,
  output logic [INSTR_W-1:0] rsp_instr_o,
  output logic [CNT_W-1:0]   outst_cnt,
  output logic               idle,
  output logic               proto_err
);

  localparam int AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   fetch_pc;
  logic [CNT_W-1:0]  drop_cnt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [PC_W-1:0]   pc_fifo [MAX_OUTST];

  logic no_outst;
  logic dropping;
  logic req_hs;
  logic rsp_hs;

  assign no_outst = (outst_cnt == '0);
  assign dropping = (drop_cnt != '0);

  assign req_vld = (state == FETCH)
                 & (outst_cnt < CNT_W'(MAX_OUTST))
                 & ~redirect_vld;
  assign req_pc  = fetch_pc;
  assign req_hs  = req_vld & req_rdy;

  // A response with nothing in flight is swallowed, never popped.
  assign rsp_rdy_i   = no_outst | dropping | rsp_rdy_o;
  assign rsp_vld_o   = rsp_vld_i & ~no_outst & ~dropping;
  assign rsp_hs      = rsp_vld_i & rsp_rdy_i & ~no_outst;
  assign rsp_pc_o    = pc_fifo[rd_ptr];
  assign rsp_instr_o = rsp_instr_i;

  assign idle = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RST_PC;
      outst_cnt <= '0;
      drop_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        pc_fifo[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_en) state <= FETCH;
        end
        FETCH: begin
          if (!fetch_en) state <= DRAIN;
        end
        DRAIN: begin
          if (fetch_en) state <= FETCH;
          else if (no_outst) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (redirect_vld) begin
        fetch_pc <= redirect_pc;
      end else if (req_hs) begin
        fetch_pc <= fetch_pc + PC_W'(4);
      end

      if (req_hs) begin
        pc_fifo[wr_ptr] <= fetch_pc;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (rsp_hs) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      if (req_hs && !rsp_hs) begin
        outst_cnt <= outst_cnt + CNT_W'(1);
      end else if (!req_hs && rsp_hs) begin
        outst_cnt <= outst_cnt - CNT_W'(1);
      end

      // Everything still in flight after this cycle's response is stale.
      if (redirect_vld) begin
        drop_cnt <= outst_cnt - CNT_W'(rsp_hs);
      end else if (rsp_hs && dropping) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end

      if (rsp_vld_i && no_outst) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule
